// File: rtl/microsequencer_pkg.sv
// ---------------------------------------------------------------------------
// microsequencer_pkg
// Shared control-unit constants for the microsequencer.
//   STATE_W  : default width of the microstore address
//   ns_sel_e : next-state select codes carried in the control register N field
// ---------------------------------------------------------------------------
package microsequencer_pkg;

  localparam int STATE_W = 10;

  typedef enum logic [2:0] {
    NS_ENC   = 3'b000,  // dispatch to encoder address
    NS_CR    = 3'b001,  // unconditional jump to cr
    NS_INC   = 3'b010,  // sequential
    NS_COND  = 3'b011,  // conditional jump on cond^inv
    NS_WAIT  = 3'b100,  // stall until moc^inv
    NS_FETCH = 3'b101,  // restart at address 0
    NS_CALL  = 3'b110,  // jump to cr, save return address
    NS_RET   = 3'b111   // return to saved address
  } ns_sel_e;

endpackage

// File: rtl/state_incrementer.sv
// ---------------------------------------------------------------------------
// state_incrementer
// Modulo-2^W increment of the current microstore address.
//   state_i : current address
//   inc_o   : state_i + 1, wrapping from all-ones to zero
// ---------------------------------------------------------------------------
module state_incrementer #(
  parameter int W = 10
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] inc_o
);

  assign inc_o = state_i + W'(1);

endmodule

// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
// Registered next-address generator for a microprogrammed control unit.
//   clk, reset          : system clock, asynchronous active-high reset
//   N, inv, cr          : select code, condition invert, jump target
//   enc_addr            : instruction-encoder dispatch address
//   cond, moc           : condition result, memory-operation-complete
//   hold                : freeze request (overrides every N code)
//   next_state          : registered microstore address
//   waiting             : combinational, high while a moc wait stalls
//   mem_timeout         : sticky, set when a wait reaches TMO_LIMIT
// ---------------------------------------------------------------------------
module microsequencer #(
  parameter int         STATE_W   = microsequencer_pkg::STATE_W,
  parameter int         CR_W      = 6,
  parameter logic [7:0] TMO_LIMIT = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         N,
  input  logic               inv,
  input  logic [CR_W-1:0]    cr,
  input  logic [STATE_W-1:0] enc_addr,
  input  logic               cond,
  input  logic               moc,
  input  logic               hold,
  output logic [STATE_W-1:0] next_state,
  output logic               waiting,
  output logic               mem_timeout
);

  import microsequencer_pkg::*;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [STATE_W-1:0] inc_w;
  logic [STATE_W-1:0] cr_ext_w;
  ns_sel_e            sel_w;

  state_incrementer #(.W(STATE_W)) u_inc (
    .state_i (state_q),
    .inc_o   (inc_w)
  );

  assign sel_w    = ns_sel_e'(N);
  assign cr_ext_w = STATE_W'(cr);
  assign waiting  = (sel_w == NS_WAIT) && !(moc ^ inv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= '0;
      ret_q      <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (!hold) begin
      unique case (sel_w)
        NS_ENC:   state_d = enc_addr;
        NS_CR:    state_d = cr_ext_w;
        NS_INC:   state_d = inc_w;
        NS_COND:  state_d = (cond ^ inv) ? cr_ext_w : inc_w;
        NS_WAIT:  state_d = (moc ^ inv) ? inc_w : state_q;
        NS_FETCH: state_d = '0;
        NS_CALL: begin
          state_d = cr_ext_w;
          ret_d   = inc_w;
        end
        NS_RET:   state_d = ret_q;
      endcase
      // Counter saturates at the limit; reaching it while still waiting
      // latches the timeout flag until reset.
      if (waiting) begin
        if (wait_cnt_q == TMO_LIMIT) timeout_d = 1'b1;
        else                         wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = '0;
      end
    end
  end

  assign next_state  = state_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] N;
  logic       inv;
  logic [5:0] cr;
  logic [9:0] enc_addr;
  logic       cond;
  logic       moc;
  logic       hold;
  logic [9:0] next_state;
  logic       waiting;
  logic       mem_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  microsequencer #(.STATE_W(10), .CR_W(6), .TMO_LIMIT(8'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .N           (N),
    .inv         (inv),
    .cr          (cr),
    .enc_addr    (enc_addr),
    .cond        (cond),
    .moc         (moc),
    .hold        (hold),
    .next_state  (next_state),
    .waiting     (waiting),
    .mem_timeout (mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      $display("ok   %-16s got=%0d exp=%0d", tag, got, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; N = 3'b010; inv = 0; cr = 0; enc_addr = 0;
    cond = 0; moc = 0; hold = 0;
    #3;
    check("rst_state", 32'(next_state), 0);
    check("rst_tmo", 32'(mem_timeout), 0);
    @(negedge clk); reset = 1'b0;

    edge1(); check("inc_1", 32'(next_state), 1);
    edge1(); check("inc_2", 32'(next_state), 2);
    edge1(); check("inc_3", 32'(next_state), 3);

    N = 3'b000; enc_addr = 10'd1023;
    edge1(); check("enc_1023", 32'(next_state), 1023);
    N = 3'b010;
    edge1(); check("inc_wrap", 32'(next_state), 0);

    N = 3'b000; enc_addr = 10'd4;
    edge1(); check("enc_4", 32'(next_state), 4);
    N = 3'b011; cr = 6'd20; cond = 1; inv = 0;
    edge1(); check("cond_taken", 32'(next_state), 20);
    N = 3'b000;
    edge1(); check("enc_4b", 32'(next_state), 4);
    N = 3'b011; inv = 1;
    edge1(); check("cond_inv", 32'(next_state), 5);
    inv = 0; cond = 0;

    N = 3'b000; enc_addr = 10'd10;
    edge1(); check("enc_10", 32'(next_state), 10);
    N = 3'b110; cr = 6'd40;
    edge1(); check("call", 32'(next_state), 40);
    N = 3'b111;
    edge1(); check("ret", 32'(next_state), 11);
    N = 3'b000; enc_addr = 10'd40;
    edge1();
    N = 3'b110; cr = 6'd50;
    edge1(); check("call_a", 32'(next_state), 50);
    cr = 6'd7;
    edge1(); check("call_nested", 32'(next_state), 7);
    N = 3'b111;
    edge1(); check("ret_overwrite", 32'(next_state), 51);

    N = 3'b101;
    edge1(); check("fetch", 32'(next_state), 0);
    N = 3'b001; cr = 6'd63;
    edge1(); check("jump_cr", 32'(next_state), 63);

    N = 3'b100; moc = 0; inv = 0;
    #1; check("waiting_comb", 32'(waiting), 1);
    for (int i = 0; i < 3; i++) begin
      edge1(); check("wait_hold", 32'(next_state), 63);
    end
    check("waiting_hi", 32'(waiting), 1);
    moc = 1;
    #1; check("waiting_lo", 32'(waiting), 0);
    edge1(); check("wait_done", 32'(next_state), 64);
    check("tmo_clear", 32'(mem_timeout), 0);
    inv = 1;
    #1; check("wait_inv", 32'(waiting), 1);
    edge1(); check("wait_inv_hold", 32'(next_state), 64);
    moc = 0;
    edge1(); check("wait_inv_done", 32'(next_state), 65);
    inv = 0;

    for (int i = 0; i < 4; i++) edge1();
    check("tmo_not_yet", 32'(mem_timeout), 0);
    edge1(); check("tmo_set", 32'(mem_timeout), 1);
    moc = 1;
    edge1(); check("tmo_advance", 32'(next_state), 66);
    check("tmo_sticky", 32'(mem_timeout), 1);

    hold = 1; N = 3'b000; enc_addr = 10'd300;
    edge1(); check("hold_freeze", 32'(next_state), 66);
    hold = 0;
    edge1(); check("hold_release", 32'(next_state), 300);

    N = 3'b100; moc = 0;
    edge1(); check("wait_300", 32'(next_state), 300);
    #2; reset = 1'b1;
    #1;
    check("async_rst_st", 32'(next_state), 0);
    check("async_rst_tmo", 32'(mem_timeout), 0);
    @(negedge clk); reset = 1'b0;
    N = 3'b010;
    edge1(); check("post_rst_inc", 32'(next_state), 1);
    N = 3'b111;
    edge1(); check("ret_no_call", 32'(next_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
